// File: rtl/dualmem_narrow_if.sv
// Bus bundle for dualmem_narrow: 64-bit word write port, 16-bit beat read
// port and the fill level. The slave modport is the converter's view.
interface dualmem_narrow_if #(
    parameter int AW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic [1:0]    in_nlanes;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_data;
    logic          out_last;
    logic [AW:0]   level;

    modport slave (
        input  in_valid, in_data, in_nlanes, out_ready,
        output in_ready, out_valid, out_data, out_last, level
    );

    modport master (
        output in_valid, in_data, in_nlanes, out_ready,
        input  in_ready, out_valid, out_data, out_last, level
    );
endinterface

// File: rtl/dualmem_narrow.sv
// dualmem_narrow: buffering 64-bit to 16-bit width converter.
// Words of up to four 16-bit lanes are queued in a DEPTH-entry FIFO together
// with their lane count and drained one lane per beat. No combinational path
// exists from the write port to the read port.
// Optional build macro NARROW_MSB_FIRST_EN: drain lanes highest-first
// (out_last then marks lane 0). Default build drains lowest-first.
module dualmem_narrow #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    dualmem_narrow_if.slave  bus
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Each entry holds {nlanes, data}.
    logic [65:0] mem [DEPTH];

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [1:0]  lane;

    logic        full;
    logic        empty;
    logic        push_en;
    logic        beat_en;
    logic        pop_en;
    logic [65:0] head;
    logic [1:0]  head_nl;
    logic [63:0] head_data;

    // Map the beat counter onto the physical lane of the head word.
    function automatic logic [1:0] lane_sel(input logic [1:0] beat, input logic [1:0] nl);
`ifdef NARROW_MSB_FIRST_EN
        lane_sel = nl - beat;
`else
        lane_sel = beat;
        if (nl == 2'd0) lane_sel = beat;  // nl unused in low-first order
`endif
    endfunction

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign head      = mem[rd_ptr[AW-1:0]];
    assign head_nl   = head[65:64];
    assign head_data = head[63:0];

    // in_ready looks only at the registered pointers, so a pop in the same
    // cycle never frees room for a push while full.
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign push_en       = bus.in_valid && !full;
    assign beat_en       = !empty && bus.out_ready;
    assign pop_en        = beat_en && (lane == head_nl);
    assign bus.level     = wr_ptr - rd_ptr;

    // Word storage; data is not reset, only the pointers that qualify it.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr[AW-1:0]] <= {bus.in_nlanes, bus.in_data};
        end
    end

    // Read/write pointers with wrap bit; flush overrides push and pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_en)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Beat counter within the head word; returns to 0 when the word pops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lane <= 2'd0;
        end else if (clr) begin
            lane <= 2'd0;
        end else if (beat_en) begin
            lane <= pop_en ? 2'd0 : lane + 2'd1;
        end
    end

    // Beat data and last flag, both forced low while nothing is queued.
    always_comb begin
        bus.out_data = 16'h0000;
        bus.out_last = 1'b0;
        if (!empty) begin
            case (lane_sel(lane, head_nl))
                2'd0:    bus.out_data = head_data[15:0];
                2'd1:    bus.out_data = head_data[31:16];
                2'd2:    bus.out_data = head_data[47:32];
                default: bus.out_data = head_data[63:48];
            endcase
            bus.out_last = (lane == head_nl);
        end
    end

endmodule

// File: tb/tb_dualmem_narrow.sv
// Directed bench for dualmem_narrow with a beat scoreboard.
module tb_dualmem_narrow;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rstn;
    logic clr;

    int checks = 0;
    int errors = 0;

    // Expected beats as {last, data}.
    logic [16:0] q[$];

    dualmem_narrow_if #(.AW(AW)) bus ();

    dualmem_narrow #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Queue the beats a word should produce, in emission order.
    task automatic enqueue(input logic [63:0] data, input logic [1:0] nl);
        logic [1:0] ln;
        for (int b = 0; b <= int'(nl); b++) begin
`ifdef NARROW_MSB_FIRST_EN
            ln = nl - 2'(b);
`else
            ln = 2'(b);
`endif
            q.push_back({(b == int'(nl)), data[16*ln +: 16]});
        end
    endtask

    // Offer one word; returns one time unit after the accepting edge.
    task automatic push_word(input logic [63:0] data, input logic [1:0] nl);
        int n = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = data;
        bus.in_nlanes = nl;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            check("push_timeout", 64'(n), 64'd0);
        end else begin
            enqueue(data, nl);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Wait for every expected beat, then let the final pop register.
    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check(tag, 64'(q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Scoreboard: every accepted beat must match the queue head.
    always @(negedge clk) begin
        if (rstn && bus.out_valid && bus.out_ready) begin
            checks++;
            if (q.size() == 0) begin
                assert (0) else begin
                    errors++;
                    $error("FAIL beat_unexpected: observed %h expected none", {bus.out_last, bus.out_data});
                end
            end else begin
                assert ({bus.out_last, bus.out_data} === q[0]) else begin
                    errors++;
                    $error("FAIL beat: observed %h expected %h", {bus.out_last, bus.out_data}, q[0]);
                end
                void'(q.pop_front());
            end
        end
    end

    // Internal push/pop must never act on a full/empty FIFO.
    always @(posedge clk) begin
        if (rstn) begin
            assert (!(dut.push_en && dut.full)) else begin
                errors++;
                $error("FAIL push_while_full: observed 1 expected 0");
            end
            assert (!(dut.pop_en && dut.empty)) else begin
                errors++;
                $error("FAIL pop_while_empty: observed 1 expected 0");
            end
        end
    end

    initial begin
        logic [16:0] held;
        rstn          = 1'b0;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_nlanes = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        // Reset / idle
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        check("rst_out_last",  64'(bus.out_last),  64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_level",     64'(bus.level),     64'd0);

        // Single full word
        bus.out_ready = 1'b1;
        push_word(64'h4444_3333_2222_1111, 2'd3);
        check("full_word_level1", 64'(bus.level), 64'd1);
        wait_drain("full_word_drain", 20);
        check("full_word_level0", 64'(bus.level), 64'd0);

        // Partial word: upper lanes never emitted
        push_word(64'hDEAD_BEEF_CAFE_0001, 2'd1);
        wait_drain("partial_drain", 20);
        check("partial_level0", 64'(bus.level), 64'd0);
        check("partial_idle",   64'(bus.out_valid), 64'd0);

        // Fill to capacity with the consumer stalled
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            push_word({16'(16'h4000 + i), 16'(16'h3000 + i), 16'(16'h2000 + i), 16'(16'h1000 + i)}, 2'd3);
        end
        check("fill_level",    64'(bus.level),    64'(DEPTH));
        check("fill_in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'hBAD0_BAD0_BAD0_BAD0;
        bus.in_nlanes = 2'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("ninth_rejected", 64'(bus.level), 64'(DEPTH));

        // Stall mid-word: two beats, then hold
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        held = q[0];
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall_hold", 64'({bus.out_last, bus.out_data}), 64'(held));
        end
        bus.out_ready = 1'b1;
        wait_drain("fill_drain", 80);
        check("fill_drain_level", 64'(bus.level), 64'd0);

        // Second fill: pointers wrap
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            push_word({16'(16'hD000 + i), 16'(16'hC000 + i), 16'(16'hB000 + i), 16'(16'hA000 + i)}, 2'(i % 4));
        end
        check("wrap_level",    64'(bus.level),    64'(DEPTH));
        check("wrap_in_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        wait_drain("wrap_drain", 80);
        check("wrap_drain_level", 64'(bus.level), 64'd0);

        // Concurrent push and pop every cycle
        bus.in_valid  = 1'b1;
        bus.in_nlanes = 2'd0;
        for (int i = 0; i < 256; i++) begin
            bus.in_data = {16'hA5A5, 16'h5A5A, 16'hFFFF, 16'(i)};
            enqueue(bus.in_data, 2'd0);
            @(posedge clk); #1;
            check("stream_level", 64'(bus.level), 64'd1);
        end
        bus.in_valid = 1'b0;
        wait_drain("stream_drain", 20);
        check("stream_level0", 64'(bus.level), 64'd0);

        // Flush after two beats with a simultaneous push
        push_word(64'h4444_3333_2222_1111, 2'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'h7777_6666_5555_4444;
        bus.in_nlanes = 2'd3;
        @(posedge clk); #1;
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        q.delete();
        check("clr_level",     64'(bus.level),     64'd0);
        check("clr_out_valid", 64'(bus.out_valid), 64'd0);
        check("clr_out_data",  64'(bus.out_data),  64'd0);
        push_word(64'h8888_7777_6666_5555, 2'd3);
        wait_drain("clr_fresh_drain", 20);

        // Same sequence with an asynchronous reset pulse
        push_word(64'h4444_3333_2222_1111, 2'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn          = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'h7777_6666_5555_4444;
        #1;
        q.delete();
        check("arst_level",     64'(bus.level),     64'd0);
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        #2;
        rstn         = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("arst_level_after", 64'(bus.level), 64'd0);
        push_word(64'h8888_7777_6666_5555, 2'd3);
        wait_drain("arst_fresh_drain", 20);
        check("final_level", 64'(bus.level), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dualmem_narrow.md
Name: dualmem_narrow

Overview:
- Single-clock buffering width converter, the read-side counterpart of the team's 16→64 widening memory.
- Accepts 64-bit words on a valid/ready write port, stores them in a DEPTH-entry FIFO, and emits them as 16-bit beats on a valid/ready read port.
- Sits between wide (64-bit) bus/DMA producers and narrow 16-bit consumers in the porting datapath.
- Supports partial words: fewer than 4 lanes per word.

Parameters:
- DEPTH, 8, number of 64-bit FIFO entries; power of two, ≥2.
- AW, 3, log2(DEPTH); pointer width.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush.
- in_valid  input  1  write word valid.
- in_ready  output  1  FIFO can accept a word.
- in_data  input  64  write word; lane k = in_data[16k+15:16k].
- in_nlanes  input  2  number of valid lanes minus 1 (0 → 1 lane … 3 → 4 lanes).
- out_valid  output  1  beat valid.
- out_ready  input  1  consumer accepts beat.
- out_data  output  16  current beat.
- out_last  output  1  current beat is the final lane of its word.
- level  output  AW+1  number of stored words, 0..DEPTH; the word currently being drained is included.

Behaviour:
- Reset (rstn=0, async): wr_ptr=0, rd_ptr=0, lane counter=0, level=0, in_ready=1, out_valid=0, out_data=0, out_last=0. Storage contents are don't-care.
- Storage: DEPTH × 66-bit entries holding {nlanes, data}. Pointers are AW+1 bits with a wrap bit.
  - full = (ptrs differ only in MSB).
  - empty = (ptrs equal).
- in_ready = !full. It is not forwarded from pop: when full, a same-cycle pop does not admit a push.
- Push: in_valid && in_ready. Entry[wr_ptr] ← {in_nlanes, in_data}; wr_ptr+1, wrapping modulo 2·DEPTH.
- Latency: a word pushed in cycle t is presented earliest in cycle t+1. There is no combinational in→out path.
- out_valid = !empty.
- out_data:
  - normal order: head.data[16·lane+15 : 16·lane].
  - forced to 0 when !out_valid.
- out_last = out_valid && (lane == head.nlanes).
- Beat handshake, out_valid && out_ready:
  - lane < head.nlanes: lane+1.
  - lane == head.nlanes: pop (rd_ptr+1), lane ← 0.
- out_valid && !out_ready: out_data, out_last and lane all hold stable.
- Beats per word = nlanes+1; lanes above nlanes are never emitted.
- Simultaneous push and pop (not full): both take effect; level unchanged.
- level = wr_ptr − rd_ptr, computed modulo 2·DEPTH. It updates the cycle after a push/pop and is registered or derived from registered pointers.
- clr=1: next cycle wr_ptr=rd_ptr=0 and lane=0. Overrides any same-cycle push and pop; the accepted push is discarded.
- Reset mid-word: the partially drained word is lost; the next word starts at lane 0.
- No overflow or underflow is possible under the handshake rules. A bench assertion fires if the internal push path is taken while full or the pop path while empty.

Optional Feature:
- Macro: NARROW_MSB_FIRST_EN.
- Defined: lanes are emitted high-first. Beat index i selects lane (nlanes − i), so the word's valid lanes 0..nlanes appear in the order nlanes, nlanes−1, …, 0. out_last is asserted on lane 0.
- Undefined (default): low lane first, as described in Behaviour.
- Handshake, level, full/empty and reset behaviour are identical in both builds.

Test Plan:
- Reset/idle: rstn low then high, no traffic → out_valid=0, out_data=0, in_ready=1, level=0.
- Single full word: push in_data=64'h4444_3333_2222_1111, nlanes=3, out_ready=1 → beats 1111, 2222, 3333, 4444 on cycles t+1..t+4; out_last only on 4444; level 1→0.
  - With NARROW_MSB_FIRST_EN: beats 4444, 3333, 2222, 1111; last on 1111.
- Partial word: push 64'hDEAD_BEEF_CAFE_0001, nlanes=1 → beats 0001, CAFE only, last on CAFE; BEEF and DEAD are never emitted.
- Full/backpressure:
  - out_ready=0, push 8 words → level=8, in_ready=0, and a 9th in_valid is not accepted.
  - Stall mid-word → out_data held.
  - Raise out_ready → all 32 beats arrive in order; pointers wrap correctly on a second fill.
- Concurrent push/pop: steady stream of nlanes=0 words with push and pop every cycle → level constant at 1; data 0x0000..0x00FF in order.
- Flush/reset mid-operation:
  - clr asserted after 2 of 4 beats, with a simultaneous push → next cycle level=0, out_valid=0.
  - A fresh word then starts at lane 0.
  - Same sequence repeated with an async rstn pulse → identical outcome.
